multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences the shared ALU, memory, IR, PC and register file across FETCH/DECODE/EXECUTE/MEM/WB steps. It drives the 3-bit ALUOp consumed by ALUControl. Memory accesses stall on a mem_ready handshake.

Parameters:
- OPC_W, 6, opcode width.
- ALUOP_W, 3, width of alu_op bus to ALUControl.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, active-high.
- opcode  in  6  instruction[31:26] from IR; sampled in DECODE.
- zero  in  1  ALU zero flag; used in BRANCH only.
- mem_ready  in  1  memory done; completes the access in the current cycle.
- alu_op  out  3  to ALUControl: 111 R-type, 100 add, 101 or, 110 and, 001 sub (beq/bne), 010 lw, 011 sw, 000 idle.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=const 4, 10=sext imm, 11=sext imm<<2.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg  out  1 each  datapath strobes/selects.
- illegal_op  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Reset: state<=FETCH, latched opcode<=0. All outputs are 0 during any cycle with reset=1. Reset mid-instruction aborts it with no further writes.
- Opcodes decoded:
  - R 000000
  - addi 001000, andi 001100, ori 001101
  - lw 100011, sw 101011
  - beq 000100, bne 000101
  - j 000010
- Outputs are Moore (decoded from state and latched opcode), except pc_write/ir_write, which also use mem_ready or zero. Unlisted outputs are 0.
- FETCH:
  - mem_read=1, iord=0, src_a=0, src_b=01, alu_op=100, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Stay while mem_ready=0; else go to DECODE.
- DECODE:
  - src_a=0, src_b=11, alu_op=100 (branch target into ALUOut); latch opcode.
  - lw/sw -> MEMADR; R -> RTYPE_EX; addi/andi/ori -> IMM_EX; beq/bne -> BRANCH; j -> JUMP.
  - Any other opcode: illegal_op=1, go to FETCH.
- MEMADR: src_a=1, src_b=10, alu_op=010 (lw) or 011 (sw). lw -> MEMRD; sw -> MEMWR.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- RTYPE_EX: src_a=1, src_b=00, alu_op=111 -> ALU_WB.
- IMM_EX: src_a=1, src_b=10, alu_op=100/110/101 for addi/andi/ori -> ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R (0 for immediate ops) -> FETCH.
- BRANCH:
  - src_a=1, src_b=00, alu_op=001, pc_source=01.
  - pc_write = zero XOR (opcode==bne).
  - -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH.
- Latency with mem_ready=1 in the same cycle (no wait states):
  - lw 5, sw 4, R/imm 4, branch 3, j 3 cycles.
  - Each mem_ready=0 cycle adds one cycle.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- mem_read and mem_write are never both 1.

Optional Feature:
MC_PERF_COUNTERS_EN
- With it: adds ports cycle_count (out, 32) and instr_retired (out, 32).
  - Both cleared by reset.
  - cycle_count increments every non-reset cycle.
  - instr_retired increments on every transition into FETCH from a non-FETCH state; illegal_op exits count too.
  - Both wrap at 2^32-1 -> 0.
- Without it: ports and logic are absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state localparams (4-bit: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, IMM_EX=7, ALU_WB=8, BRANCH=9, JUMP=10);
  - opcode constants;
  - ALUOp encodings, shared with ALUControl;
  - src_b/pc_source select codes.
- One sub-module, mc_perf_counter (two 32-bit counters), instantiated only under MC_PERF_COUNTERS_EN.

Test Plan:
- Reset held 3 cycles with mem_ready=1 -> all outputs 0. First cycle after release: FETCH, mem_read=1, alu_op=100, pc_write=ir_write=1.
- lw (100011) with mem_ready=0 for 2 cycles in MEMRD -> states FETCH,DECODE,MEMADR,MEMRD,MEMRD,MEMRD,MEMWB. alu_op=010 in MEMADR; reg_write=1, mem_to_reg=1 only in MEMWB; 7 cycles total.
- R-type (000000) then addi (001000) then ori (001101) -> alu_op=111 / 100 / 101 in the execute cycle. reg_dst=1 for R, 0 for the others in ALU_WB.
- beq with zero=1 -> pc_write=1, pc_source=01 in BRANCH. bne with zero=1 -> pc_write=0. j -> pc_write=1, pc_source=10.
- opcode 111111 -> illegal_op=1 for exactly the DECODE cycle, no reg_write/mem_write, next state FETCH.
- reset asserted during MEMWR with mem_ready=0 -> mem_write=0 that cycle, FETCH next. With MC_PERF_COUNTERS_EN: instr_retired counts one per completed instruction.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes,
// ALUOp values (shared with ALUControl) and datapath select codes.
package mc_ctrl_pkg;

  localparam int OPC_WIDTH   = 6;
  localparam int ALUOP_WIDTH = 3;
  localparam int PERF_CNT_W  = 32;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_IMM_EX   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  localparam logic [OPC_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_WIDTH-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_WIDTH-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_WIDTH-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_WIDTH-1:0] OP_J     = 6'b000010;

  localparam logic [ALUOP_WIDTH-1:0] ALUOP_IDLE = 3'b000;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB  = 3'b001;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_LW   = 3'b010;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_SW   = 3'b011;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD  = 3'b100;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR   = 3'b101;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND  = 3'b110;
  localparam logic [ALUOP_WIDTH-1:0] ALUOP_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_REG_B   = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_perf_counter.sv
// Free-running cycle counter and retired-instruction counter for the
// multi-cycle control FSM; both wrap naturally at 2^32.
module mc_perf_counter
  import mc_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  retire,
  output logic [PERF_CNT_W-1:0] cycle_count,
  output logic [PERF_CNT_W-1:0] instr_retired
);

  logic [PERF_CNT_W-1:0] cyc_q, cyc_d;
  logic [PERF_CNT_W-1:0] ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q + 1'b1;
    ret_d = retire ? ret_q + 1'b1 : ret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cycle_count   = cyc_q;
  assign instr_retired = ret_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Optional performance counters are built when MC_PERF_COUNTERS_EN is defined.
//
// state    | meaning
// FETCH    | read instruction, PC+4 into PC once memory is ready
// DECODE   | latch opcode, branch target into ALUOut, dispatch
// MEMADR   | compute load/store address
// MEMRD    | data read, waits for mem_ready
// MEMWB    | load data into rt
// MEMWR    | data write, waits for mem_ready
// RTYPE_EX | R-type ALU operation
// IMM_EX   | addi/andi/ori ALU operation
// ALU_WB   | ALU result into rd (R) or rt (imm)
// BRANCH   | beq/bne compare, conditional PC update
// JUMP     | PC <= jump target
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               pc_write,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op
`ifdef MC_PERF_COUNTERS_EN
  ,
  output logic [31:0]        cycle_count,
  output logic [31:0]        instr_retired
`endif
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    alu_op     = ALUOP_IDLE;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG_B;
    pc_source  = PCSRC_ALU;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALUOP_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_SEXT_SH;
        alu_op    = ALUOP_ADD;
        opc_d     = opcode;
        case (opcode)
          OP_LW, OP_SW:             state_d = S_MEMADR;
          OP_RTYPE:                 state_d = S_RTYPE_EX;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EX;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        alu_op    = (opc_q == OP_SW) ? ALUOP_SW : ALUOP_LW;
        state_d   = (opc_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
        state_d   = S_ALU_WB;
      end
      S_IMM_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
        case (opc_q)
          OP_ANDI: alu_op = ALUOP_AND;
          OP_ORI:  alu_op = ALUOP_OR;
          default: alu_op = ALUOP_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opc_q == OP_RTYPE);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_source = PCSRC_ALUOUT;
        pc_write  = zero ^ (opc_q == OP_BNE);
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // A reset cycle must never strobe the datapath, even mid-instruction.
    if (reset) begin
      alu_op     = ALUOP_IDLE;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG_B;
      pc_source  = PCSRC_ALU;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

`ifdef MC_PERF_COUNTERS_EN
  logic retire;
  assign retire = !reset && (state_q != S_FETCH) && (state_d == S_FETCH);

  mc_perf_counter u_perf (
    .clk          (clk),
    .reset        (reset),
    .retire       (retire),
    .cycle_count  (cycle_count),
    .instr_retired(instr_retired)
  );
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: a per-instruction
// cycle-trace model drives inputs and supplies the expected outputs.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       pc_write, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
`ifdef MC_PERF_COUNTERS_EN
  logic [31:0] cycle_count, instr_retired;
`endif

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .alu_op    (alu_op),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .pc_source (pc_source),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .iord      (iord),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op)
`ifdef MC_PERF_COUNTERS_EN
    ,
    .cycle_count  (cycle_count),
    .instr_retired(instr_retired)
`endif
  );

  // One expected cycle: inputs to drive plus the full expected output vector.
  typedef struct packed {
    logic        mr;
    logic        zr;
    logic [5:0]  opc;
    logic [16:0] exp;
    logic        last;
  } ent_t;

  ent_t  tr[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc_m = 0;
  int    ret_m = 0;
  string cur_instr = "reset";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%s] t=%0t: got %0h expected %0h", tag, cur_instr, $time, got, exp);
    end
  endtask

  // {illegal, alu_op, src_a, src_b, pc_src, pc_write, ir_write, iord, mem_read,
  //  mem_write, reg_write, reg_dst, mem_to_reg}
  function automatic logic [16:0] o(input logic ill, input logic [2:0] aop, input logic sa,
                                    input logic [1:0] sb, input logic [1:0] ps, input logic pw,
                                    input logic irw, input logic io, input logic mrd,
                                    input logic mwr, input logic rw, input logic rd,
                                    input logic m2r);
    return {ill, aop, sa, sb, ps, pw, irw, io, mrd, mwr, rw, rd, m2r};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b100011,
                      6'b101011, 6'b000100, 6'b000101, 6'b000010};
  endfunction

  task automatic add(input logic mr, input logic zr, input logic [5:0] opc,
                     input logic [16:0] exp, input logic last);
    ent_t e;
    e.mr = mr; e.zr = zr; e.opc = opc; e.exp = exp; e.last = last;
    tr.push_back(e);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  // Expected cycle trace of one instruction; opcode is only meaningful in DECODE,
  // so every other cycle drives a random opcode.
  task automatic gen_instr(input logic [5:0] op, input int wf, input int wm, input int zsel);
    logic       z;
    logic [2:0] aop;
    tr.delete();
    for (int i = 0; i < wf; i++) add(1'b0, rb(), ro(), o(0,3'b100,0,2'b01,2'b00,0,0,0,1,0,0,0,0), 1'b0);
    add(1'b1, rb(), ro(), o(0,3'b100,0,2'b01,2'b00,1,1,0,1,0,0,0,0), 1'b0);
    add(rb(), rb(), op, o(!is_legal(op),3'b100,0,2'b11,2'b00,0,0,0,0,0,0,0,0), !is_legal(op));
    case (op)
      6'b000000: begin
        add(rb(), rb(), ro(), o(0,3'b111,1,2'b00,2'b00,0,0,0,0,0,0,0,0), 1'b0);
        add(rb(), rb(), ro(), o(0,3'b000,0,2'b00,2'b00,0,0,0,0,0,1,1,0), 1'b1);
      end
      6'b001000, 6'b001100, 6'b001101: begin
        aop = (op == 6'b001000) ? 3'b100 : (op == 6'b001100) ? 3'b110 : 3'b101;
        add(rb(), rb(), ro(), o(0,aop,1,2'b10,2'b00,0,0,0,0,0,0,0,0), 1'b0);
        add(rb(), rb(), ro(), o(0,3'b000,0,2'b00,2'b00,0,0,0,0,0,1,0,0), 1'b1);
      end
      6'b100011: begin
        add(rb(), rb(), ro(), o(0,3'b010,1,2'b10,2'b00,0,0,0,0,0,0,0,0), 1'b0);
        for (int i = 0; i < wm; i++) add(1'b0, rb(), ro(), o(0,3'b000,0,2'b00,2'b00,0,0,1,1,0,0,0,0), 1'b0);
        add(1'b1, rb(), ro(), o(0,3'b000,0,2'b00,2'b00,0,0,1,1,0,0,0,0), 1'b0);
        add(rb(), rb(), ro(), o(0,3'b000,0,2'b00,2'b00,0,0,0,0,0,1,0,1), 1'b1);
      end
      6'b101011: begin
        add(rb(), rb(), ro(), o(0,3'b011,1,2'b10,2'b00,0,0,0,0,0,0,0,0), 1'b0);
        for (int i = 0; i < wm; i++) add(1'b0, rb(), ro(), o(0,3'b000,0,2'b00,2'b00,0,0,1,0,1,0,0,0), 1'b0);
        add(1'b1, rb(), ro(), o(0,3'b000,0,2'b00,2'b00,0,0,1,0,1,0,0,0), 1'b1);
      end
      6'b000100, 6'b000101: begin
        z = (zsel == 2) ? rb() : 1'(zsel);
        add(rb(), z, ro(), o(0,3'b001,1,2'b00,2'b01,z ^ (op == 6'b000101),0,0,0,0,0,0,0), 1'b1);
      end
      6'b000010: add(rb(), rb(), ro(), o(0,3'b000,0,2'b00,2'b10,1,0,0,0,0,0,0,0), 1'b1);
      default: ;
    endcase
  endtask

  task automatic step(input ent_t e, input logic rst);
    reset     = rst;
    mem_ready = e.mr;
    zero      = e.zr;
    opcode    = e.opc;
    @(negedge clk);
    check("outs", 32'({illegal_op, alu_op, alu_src_a, alu_src_b, pc_source, pc_write, ir_write,
                       iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg}), 32'(e.exp));
`ifdef MC_PERF_COUNTERS_EN
    check("cycle_count", cycle_count, cyc_m);
    check("instr_retired", instr_retired, ret_m);
`endif
    @(posedge clk);
    if (rst) begin
      cyc_m = 0;
      ret_m = 0;
    end else begin
      cyc_m++;
      if (e.last) ret_m++;
    end
    #1;
  endtask

  task automatic reset_step(input logic mr);
    ent_t e;
    e.mr = mr; e.zr = rb(); e.opc = ro(); e.exp = '0; e.last = 1'b0;
    step(e, 1'b1);
  endtask

  task automatic run_trace(input int n);
    int k = 0;
    while (tr.size() > 0 && k < n) begin
      step(tr.pop_front(), 1'b0);
      k++;
    end
  endtask

  task automatic do_instr(input string name, input logic [5:0] op, input int wf, input int wm,
                          input int zsel);
    cur_instr = name;
    gen_instr(op, wf, wm, zsel);
    run_trace(1000);
  endtask

  logic [5:0] ops[9] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b100011,
                         6'b101011, 6'b000100, 6'b000101, 6'b000010};

  initial begin
    logic [5:0] op;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0;
    #1;
    for (int i = 0; i < 3; i++) reset_step(1'b1);

    do_instr("lw_wait2", 6'b100011, 0, 2, 2);
    do_instr("rtype",    6'b000000, 0, 0, 2);
    do_instr("addi",     6'b001000, 1, 0, 2);
    do_instr("ori",      6'b001101, 0, 0, 2);
    do_instr("beq_z1",   6'b000100, 0, 0, 1);
    do_instr("bne_z1",   6'b000101, 0, 0, 1);
    do_instr("beq_z0",   6'b000100, 0, 0, 0);
    do_instr("bne_z0",   6'b000101, 0, 0, 0);
    do_instr("j",        6'b000010, 0, 0, 2);
    do_instr("illegal",  6'b111111, 0, 0, 2);
    do_instr("sw",       6'b101011, 0, 1, 2);

    cur_instr = "sw_reset";
    gen_instr(6'b101011, 0, 3, 2);
    run_trace(4);
    tr.delete();
    reset_step(1'b0);
    do_instr("after_rst", 6'b000000, 0, 0, 2);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = ro(); while (is_legal(op));
        do_instr("rnd_illegal", op, $urandom_range(0, 2), 0, 2);
      end else begin
        do_instr("rnd", ops[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 2), 2);
      end
    end

    cur_instr = "final_reset";
    reset_step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
